mult6_arbiter: RTL and testbench
================================

Name: mult6_arbiter

Overview:
- Sequences and shares one combinational 6x6 unsigned array multiplier (A[5:0], B[5:0] -> S[11:0]) between two requesters.
- Latches the granted operands into registers that drive the multiplier inputs.
- Waits a programmable number of clock cycles for the ripple-adder array (gate-delayed FullAdder/HalfAdder cells) to settle, captures the product and returns it over a valid/ready response channel to the requester that issued it.
- Sits between requester logic and a single multiplier instance; the multiplier itself stays outside this block.

Parameters:
- N, 6, multiplicand width (mul_a, reqX_a).
- M, 6, multiplier width (mul_b, reqX_b).
- SETTLE_CYCLES, 2, clock cycles between operands appearing on mul_a/mul_b and sampling mul_s; legal range >= 1. SETTLE_CYCLES * clock period must be >= worst-case multiplier delay.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_ready  out  1  requester 0 pair accepted this cycle when valid&ready.
- req0_a  in  N  requester 0 multiplicand.
- req0_b  in  M  requester 0 multiplier.
- rsp0_valid  out  1  product for requester 0 available.
- rsp0_ready  in  1  requester 0 takes product.
- rsp0_p  out  N+M  product for requester 0.
- req1_valid, req1_ready, req1_a, req1_b, rsp1_valid, rsp1_ready, rsp1_p: identical to the requester 0 ports, for requester 1.
- mul_a  out  N  registered operand to multiplier A input.
- mul_b  out  M  registered operand to multiplier B input.
- mul_s  in  N+M  multiplier product S.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE; mul_a=0, mul_b=0; rsp0_valid=rsp1_valid=0; rsp0_p=rsp1_p=0; busy=0; settle counter=0; last_grant=1, so requester 0 wins the first tie.
- States: IDLE -> SETTLE -> RESP -> IDLE. Only one operation is in flight at a time; there is no pipelining.
- IDLE:
  - reqX_ready is combinational and asserted only for the arbitration winner; the loser's ready is 0.
  - Winner rule: if only one valid, that one wins; if both valid, the requester != last_grant wins; if none valid, both ready=0.
  - reqX_ready must not depend on rsp ports.
  - On accept (valid&ready at edge k): mul_a<=reqX_a, mul_b<=reqX_b, grant<=X, last_grant<=X, counter<=SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - Both ready=0.
  - Decrement the counter each cycle. In the cycle the counter is 0, at the next edge capture rspX_p<=mul_s for the granted X, set rspX_valid<=1 and go to RESP.
  - Net effect: capture at edge k+SETTLE_CYCLES. rsp_valid is first visible in the cycle after edge k+SETTLE_CYCLES.
- RESP:
  - Both ready=0.
  - rspX_valid and rspX_p held stable until rspX_ready.
  - On the rspX_valid&rspX_ready edge: rspX_valid<=0, go to IDLE.
  - rspX_p keeps its last value; it is don't-care while valid=0.
  - The non-granted requester's rsp_valid stays 0 throughout.
- mul_a/mul_b change only on accept. They hold through SETTLE and RESP so the combinational product stays stable.
- Minimum spacing from one accept to the next = SETTLE_CYCLES + 2 cycles, when rsp_ready is already high on entry to RESP.
- Width: product is unsigned N+M bits, no truncation. 63*63 = 3969 = 0xF81.
- rsp_ready asserted outside RESP, or by the non-granted requester: ignored.
- req_valid dropped while waiting in IDLE: no accept, no state change. Requesters must hold operands until ready; the block does not check this.
- Reset mid-operation (SETTLE or RESP): in-flight operation is discarded, no response is produced, and all reset values apply immediately.
- Simultaneous events: a new request arriving during RESP is not accepted until IDLE. The rsp handshake and the next accept cannot occur on the same edge.

Test Plan:
- Single request: req0 a=3,b=7 (SETTLE_CYCLES=2) -> req0_ready=1 in accept cycle; rsp0_valid rises 2 cycles after accept edge with rsp0_p=21; rsp1_valid stays 0.
- Tie and alternation: req0 and req1 held valid continuously with req0 (10,11) and req1 (2,3), rsp_ready=1 -> grant order 0,1,0,1; products 110, 6, 110, 6; accepts spaced 4 cycles apart.
- Backpressure: req1 a=63,b=63 with rsp1_ready=0 for 5 cycles -> rsp1_valid stays high, rsp1_p=0xF81 stable; req0 valid during this time sees req0_ready=0; accept of req0 occurs the cycle after the rsp1 handshake.
- Boundaries: a=0,b=45 -> 0; a=1,b=1 -> 1; a=63,b=1 -> 63. With SETTLE_CYCLES=1, a=2,b=3 -> capture 1 cycle after accept, rsp_p=6.
- Reset mid-op: assert rst during SETTLE for a=5,b=5 -> busy=0, mul_a=0, mul_b=0, rsp valids=0 immediately; after release, simultaneous req0/req1 grants req0 first.
- Stray handshake: pulse rsp0_ready in IDLE and rsp1_ready while serving req0 -> no state change, and rsp0 still delivers the correct product.

Source files
------------

// File: rtl/mult6_arbiter.sv
// Two-requester front end for one shared combinational array multiplier.
// It accepts one operand pair at a time, waits for the array to settle, and returns the product to whichever requester issued it.
module mult6_arbiter #(
  parameter int N             = 6,
  parameter int M             = 6,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [N-1:0]     req0_a,
  input  logic [M-1:0]     req0_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [N+M-1:0]   rsp0_p,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [N-1:0]     req1_a,
  input  logic [M-1:0]     req1_b,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [N+M-1:0]   rsp1_p,
  output logic [N-1:0]     mul_a,
  output logic [M-1:0]     mul_b,
  input  logic [N+M-1:0]   mul_s,
  output logic             busy
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           grant_q, grant_d;
  logic           last_grant_q, last_grant_d;
  logic [N-1:0]   mul_a_q, mul_a_d;
  logic [M-1:0]   mul_b_q, mul_b_d;
  logic           rsp0_valid_q, rsp0_valid_d;
  logic           rsp1_valid_q, rsp1_valid_d;
  logic [N+M-1:0] rsp0_p_q, rsp0_p_d;
  logic [N+M-1:0] rsp1_p_q, rsp1_p_d;
  logic           pick1;

  // Requester 1 wins when it is alone, or on a tie when requester 0 went last.
  assign pick1      = req1_valid & (~req0_valid | ~last_grant_q);
  assign req0_ready = (state_q == IDLE) & req0_valid & ~pick1;
  assign req1_ready = (state_q == IDLE) & pick1;

  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_p     = rsp0_p_q;
  assign rsp1_p     = rsp1_p_q;
  assign busy       = (state_q != IDLE);

  always_comb begin
    // NOTE: every next-state value defaults to its current value first, so no path through the case leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp0_p_d     = rsp0_p_q;
    rsp1_p_d     = rsp1_p_q;

    case (state_q)
      IDLE: begin
        if (req0_ready) begin
          mul_a_d      = req0_a;
          mul_b_d      = req0_b;
          grant_d      = 1'b0;
          last_grant_d = 1'b0;
          cnt_d        = CW'(SETTLE_CYCLES - 1);
          state_d      = SETTLE;
        end else if (req1_ready) begin
          mul_a_d      = req1_a;
          mul_b_d      = req1_b;
          grant_d      = 1'b1;
          last_grant_d = 1'b1;
          cnt_d        = CW'(SETTLE_CYCLES - 1);
          state_d      = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          if (grant_q) begin
            rsp1_p_d     = mul_s;
            rsp1_valid_d = 1'b1;
          end else begin
            rsp0_p_d     = mul_s;
            rsp0_valid_d = 1'b1;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        // Only the granted requester's ready can close the response.
        if (grant_q ? rsp1_ready : rsp0_ready) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_p_q     <= '0;
      rsp1_p_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_p_q     <= rsp0_p_d;
      rsp1_p_q     <= rsp1_p_d;
    end
  end

endmodule

// File: tb/tb_mult6_arbiter.sv
// Directed bench for mult6_arbiter: one instance with a 2-cycle settle window, one with a 1-cycle window.
// The shared multiplier is a behavioural product.
module tb_mult6_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // Instance with SETTLE_CYCLES = 2
  logic        req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
  logic [5:0]  req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic [11:0] rsp0_p, rsp1_p, mul_s;
  logic [5:0]  mul_a, mul_b;

  assign mul_s = {6'd0, mul_a} * {6'd0, mul_b};

  mult6_arbiter #(.N(6), .M(6), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_p(rsp0_p),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_p(rsp1_p),
    .mul_a(mul_a), .mul_b(mul_b), .mul_s(mul_s), .busy(busy)
  );

  // Instance with SETTLE_CYCLES = 1, exercised through requester 0 only
  logic        b_req0_valid = 0, b_rsp0_ready = 0, b_req1_valid = 0, b_rsp1_ready = 0;
  logic [5:0]  b_req0_a = 0, b_req0_b = 0, b_req1_a = 0, b_req1_b = 0;
  logic        b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid, b_busy;
  logic [11:0] b_rsp0_p, b_rsp1_p, b_mul_s;
  logic [5:0]  b_mul_a, b_mul_b;

  assign b_mul_s = {6'd0, b_mul_a} * {6'd0, b_mul_b};

  mult6_arbiter #(.N(6), .M(6), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_a(b_req0_a), .req0_b(b_req0_b),
    .rsp0_valid(b_rsp0_valid), .rsp0_ready(b_rsp0_ready), .rsp0_p(b_rsp0_p),
    .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_a(b_req1_a), .req1_b(b_req1_b),
    .rsp1_valid(b_rsp1_valid), .rsp1_ready(b_rsp1_ready), .rsp1_p(b_rsp1_p),
    .mul_a(b_mul_a), .mul_b(b_mul_b), .mul_s(b_mul_s), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One complete requester-0 transaction on the 2-cycle instance.
  task automatic op0(input logic [5:0] a, input logic [5:0] b, input logic [11:0] exp, input bit stray);
    req0_valid = 1; req0_a = a; req0_b = b; #1;
    check("op_req0_ready", req0_ready, 1);
    check("op_req1_ready", req1_ready, 0);
    @(negedge clk);
    req0_valid = 0;
    if (stray) rsp1_ready = 1;
    #1;
    check("op_busy", busy, 1);
    check("op_mul_a", mul_a, a);
    check("op_mul_b", mul_b, b);
    check("op_rsp0_early1", rsp0_valid, 0);
    @(negedge clk);
    check("op_rsp0_early2", rsp0_valid, 0);
    check("op_busy_settle", busy, 1);
    @(negedge clk);
    check("op_rsp0_valid", rsp0_valid, 1);
    check("op_rsp0_p", rsp0_p, exp);
    check("op_rsp1_quiet", rsp1_valid, 0);
    rsp0_ready = 1;
    @(negedge clk);
    rsp0_ready = 0; rsp1_ready = 0; #1;
    check("op_rsp0_done", rsp0_valid, 0);
    check("op_idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_acc;
    bit g;

    // Reset state
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    check("rst_rsp0_valid", rsp0_valid, 0);
    check("rst_rsp1_valid", rsp1_valid, 0);
    check("rst_rsp0_p", rsp0_p, 0);
    check("rst_rsp1_p", rsp1_p, 0);
    check("rst_req0_ready", req0_ready, 0);
    rst = 0;
    @(negedge clk);

    // Single request
    op0(6'd3, 6'd7, 12'd21, 0);

    // Stray rsp0_ready in IDLE, then stray rsp1_ready while serving req0
    rsp0_ready = 1;
    @(negedge clk);
    check("stray_idle_busy", busy, 0);
    check("stray_idle_rsp0", rsp0_valid, 0);
    rsp0_ready = 0;
    op0(6'd5, 6'd9, 12'd45, 1);

    // Boundaries
    op0(6'd0, 6'd45, 12'd0, 0);
    op0(6'd1, 6'd1, 12'd1, 0);
    op0(6'd63, 6'd1, 12'd63, 0);

    // Backpressure on requester 1 while requester 0 waits
    req1_valid = 1; req1_a = 63; req1_b = 63; #1;
    check("bp_req1_ready", req1_ready, 1);
    @(negedge clk);
    req1_valid = 0; req0_valid = 1; req0_a = 5; req0_b = 9;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp1_valid", rsp1_valid, 1);
      check("bp_rsp1_p", rsp1_p, 12'hF81);
      check("bp_req0_ready", req0_ready, 0);
      check("bp_mul_a", mul_a, 63);
      check("bp_rsp0_quiet", rsp0_valid, 0);
      @(negedge clk);
    end
    rsp1_ready = 1; #1;
    check("bp_req0_ready_resp", req0_ready, 0);
    @(negedge clk);
    rsp1_ready = 0; #1;
    check("bp_rsp1_done", rsp1_valid, 0);
    check("bp_idle", busy, 0);
    check("bp_req0_ready_now", req0_ready, 1);
    @(negedge clk);
    req0_valid = 0; #1;
    check("bp_req0_acc_mul_a", mul_a, 5);
    @(negedge clk);
    @(negedge clk);
    check("bp_rsp0_valid", rsp0_valid, 1);
    check("bp_rsp0_p", rsp0_p, 45);
    rsp0_ready = 1;
    @(negedge clk);
    rsp0_ready = 0;

    // Reset during SETTLE
    req0_valid = 1; req0_a = 5; req0_b = 5;
    @(negedge clk);
    req0_valid = 0; #1;
    check("mid_busy_pre", busy, 1);
    rst = 1; #1;
    check("mid_busy", busy, 0);
    check("mid_mul_a", mul_a, 0);
    check("mid_mul_b", mul_b, 0);
    check("mid_rsp0_valid", rsp0_valid, 0);
    check("mid_rsp1_valid", rsp1_valid, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    @(negedge clk);
    check("mid_no_rsp", rsp0_valid, 0);
    check("mid_still_idle", busy, 0);
    req0_valid = 1; req0_a = 4; req0_b = 4;
    req1_valid = 1; req1_a = 7; req1_b = 7; #1;
    check("mid_tie_req0", req0_ready, 1);
    check("mid_tie_req1", req1_ready, 0);
    @(negedge clk);
    req0_valid = 0; #1;
    check("mid_mul_a_acc", mul_a, 4);
    @(negedge clk);
    @(negedge clk);
    check("mid_rsp0_p", rsp0_p, 16);
    rsp0_ready = 1;
    @(negedge clk);
    rsp0_ready = 0; #1;
    check("mid_req1_next", req1_ready, 1);
    @(negedge clk);
    req1_valid = 0;
    @(negedge clk);
    @(negedge clk);
    check("mid_rsp1_valid2", rsp1_valid, 1);
    check("mid_rsp1_p", rsp1_p, 49);
    rsp1_ready = 1;
    @(negedge clk);
    rsp1_ready = 0;

    // Tie and alternation with both requesters held valid
    req0_valid = 1; req0_a = 10; req0_b = 11;
    req1_valid = 1; req1_a = 2;  req1_b = 3;
    rsp0_ready = 1; rsp1_ready = 1;
    last_acc = 0;
    for (int i = 0; i < 4; i++) begin
      g = (i % 2) == 1;
      #1;
      check("alt_ready0", req0_ready, !g);
      check("alt_ready1", req1_ready, g);
      if (i > 0) check("alt_spacing", cyc - last_acc, 4);
      last_acc = cyc;
      @(negedge clk); #1;
      check("alt_ready_settle", req0_ready | req1_ready, 0);
      @(negedge clk);
      @(negedge clk);
      check("alt_rsp_valid", g ? rsp1_valid : rsp0_valid, 1);
      check("alt_rsp_other", g ? rsp0_valid : rsp1_valid, 0);
      check("alt_rsp_p", g ? rsp1_p : rsp0_p, g ? 6 : 110);
      @(negedge clk);
    end
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    @(negedge clk);

    // SETTLE_CYCLES = 1 instance
    b_req0_valid = 1; b_req0_a = 2; b_req0_b = 3; #1;
    check("s1_ready", b_req0_ready, 1);
    @(negedge clk);
    b_req0_valid = 0; #1;
    check("s1_busy", b_busy, 1);
    check("s1_rsp_early", b_rsp0_valid, 0);
    @(negedge clk);
    check("s1_rsp_valid", b_rsp0_valid, 1);
    check("s1_rsp_p", b_rsp0_p, 6);
    b_rsp0_ready = 1;
    @(negedge clk);
    b_rsp0_ready = 0; #1;
    check("s1_done", b_rsp0_valid, 0);
    check("s1_idle", b_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
